// File: rtl/idu_inst_queue_pkg.sv
// Shared definitions for the decode instruction queue: default data widths
// and the lane-mask helpers used for push/pop accounting.
package idu_inst_queue_pkg;

    localparam int INST_W_DEF = 32;
    localparam int PC_W_DEF   = 32;

    // Lane masks are at most four bits wide; narrower masks are zero-extended.
    function automatic logic [2:0] popcount4(input logic [3:0] v);
        popcount4 = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

    function automatic logic is_therm4(input logic [3:0] v);
        is_therm4 = ((v & (v + 4'd1)) == 4'd0);
    endfunction

    function automatic logic [2:0] prefix_len4(input logic [3:0] v);
        logic run;
        run = 1'b1;
        prefix_len4 = 3'd0;
        for (int i = 0; i < 4; i++) begin
            run = run & v[i];
            if (run) prefix_len4 = prefix_len4 + 3'd1;
        end
    endfunction

endpackage

// File: rtl/idu_inst_queue_ram.sv
// Entry storage for the instruction queue: multi-port synchronous write,
// asynchronous read, contents deliberately not reset.
module idu_iq_ram #(
    parameter int DEPTH   = 8,
    parameter int FETCH_W = 2,
    parameter int DISP_W  = 2,
    parameter int DW      = 65
) (
    input  logic                     clk,
    input  logic [FETCH_W-1:0]       wr_en_i,
    input  logic [$clog2(DEPTH)-1:0] wr_addr_i [FETCH_W],
    input  logic [DW-1:0]            wr_data_i [FETCH_W],
    input  logic [$clog2(DEPTH)-1:0] rd_addr_i [DISP_W],
    output logic [DW-1:0]            rd_data_o [DISP_W]
);

    logic [DW-1:0] mem_q [DEPTH];

    // Write addresses within one beat are always distinct consecutive slots.
    always_ff @(posedge clk) begin
        for (int k = 0; k < FETCH_W; k++) begin
            if (wr_en_i[k]) mem_q[wr_addr_i[k]] <= wr_data_i[k];
        end
    end

    always_comb begin
        for (int j = 0; j < DISP_W; j++) begin
            rd_data_o[j] = mem_q[rd_addr_i[j]];
        end
    end

endmodule

// File: rtl/idu_inst_queue.sv
// Decode-stage instruction queue: absorbs fetch beats of up to FETCH_W lanes
// and presents the oldest DISP_W entries to dispatch, with optional bypass.
module idu_inst_queue
    import idu_inst_queue_pkg::*;
#(
    parameter int FETCH_W   = 2,
    parameter int DISP_W    = 2,
    parameter int DEPTH     = 8,
    parameter int BYPASS_EN = 0,
    parameter int INST_W    = INST_W_DEF,
    parameter int PC_W      = PC_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic [FETCH_W-1:0]        fetch_vld,
    input  logic [FETCH_W*INST_W-1:0] fetch_inst,
    input  logic [FETCH_W*PC_W-1:0]   fetch_pc,
    input  logic [FETCH_W-1:0]        fetch_unalign,
    output logic                      queue_full,
    output logic [DISP_W-1:0]         out_vld,
    output logic [DISP_W*INST_W-1:0]  out_inst,
    output logic [DISP_W*PC_W-1:0]    out_pc,
    output logic [DISP_W-1:0]         out_unalign,
    input  logic [DISP_W-1:0]         dispatch_vld,
    output logic [$clog2(DEPTH):0]    occupancy,
    output logic                      err_overflow,
    output logic                      err_underflow
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;
    localparam int DW = INST_W + PC_W + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
    localparam logic [PW-1:0] FETCH_P = PW'(FETCH_W);

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] occ_q, occ_d;
    logic          err_ovf_q, err_ovf_d;
    logic          err_unf_q, err_unf_d;

    logic [DW-1:0]      fetch_ent [FETCH_W];
    logic [DW-1:0]      lane_ent  [DISP_W];
    logic [DW-1:0]      rd_data   [DISP_W];
    logic [IW-1:0]      rd_addr   [DISP_W];
    logic [IW-1:0]      wr_addr   [FETCH_W];
    logic [FETCH_W-1:0] wr_en;

    logic [PW-1:0] push_cnt, pop_cnt, stored_pop, byp_pop, push_store;
    logic          disp_bad;

    // Handshake: a lane transfers when out_vld[j] & dispatch_vld[j] over a
    // thermometer prefix from lane 0; fetch lanes are accepted iff !queue_full.
    assign queue_full    = (DEPTH_P - occ_q) < FETCH_P;
    assign occupancy     = occ_q;
    assign err_overflow  = err_ovf_q;
    assign err_underflow = err_unf_q;

    always_comb begin
        for (int k = 0; k < FETCH_W; k++) begin
            fetch_ent[k] = {fetch_unalign[k], fetch_pc[k*PC_W +: PC_W],
                            fetch_inst[k*INST_W +: INST_W]};
        end
    end

    always_comb begin
        for (int j = 0; j < DISP_W; j++) begin
            rd_addr[j] = IW'(rd_ptr_q + PW'(j));
        end
    end

    idu_iq_ram #(
        .DEPTH   (DEPTH),
        .FETCH_W (FETCH_W),
        .DISP_W  (DISP_W),
        .DW      (DW)
    ) u_ram (
        .clk       (clk),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_addr),
        .wr_data_i (fetch_ent),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data)
    );

    // Lanes past the stored entries show the incoming beat when bypass is on.
    always_comb begin
        out_vld     = '0;
        out_inst    = '0;
        out_pc      = '0;
        out_unalign = '0;
        for (int j = 0; j < DISP_W; j++) begin
            lane_ent[j] = '0;
            if (PW'(j) < occ_q) begin
                out_vld[j]  = 1'b1;
                lane_ent[j] = rd_data[j];
            end else if (BYPASS_EN != 0 && !flush) begin
                for (int k = 0; k < FETCH_W; k++) begin
                    if (fetch_vld[k] && (occ_q + PW'(k) == PW'(j))) begin
                        out_vld[j]  = 1'b1;
                        lane_ent[j] = fetch_ent[k];
                    end
                end
            end
            out_inst[j*INST_W +: INST_W] = lane_ent[j][INST_W-1:0];
            out_pc[j*PC_W +: PC_W]       = lane_ent[j][INST_W +: PC_W];
            out_unalign[j]               = lane_ent[j][DW-1];
        end
    end

    always_comb begin
        push_cnt   = PW'(popcount4(4'(fetch_vld)));
        pop_cnt    = PW'(prefix_len4(4'(dispatch_vld & out_vld)));
        disp_bad   = (|(dispatch_vld & ~out_vld)) || !is_therm4(4'(dispatch_vld));
        stored_pop = (pop_cnt < occ_q) ? pop_cnt : occ_q;
        // Pops beyond the stored entries consumed leading fetch lanes directly.
        byp_pop    = pop_cnt - stored_pop;
        push_store = queue_full ? '0 : (push_cnt - byp_pop);
        for (int k = 0; k < FETCH_W; k++) begin
            wr_en[k]   = !flush && !queue_full && fetch_vld[k] && (PW'(k) >= byp_pop);
            wr_addr[k] = IW'(wr_ptr_q + PW'(k) - byp_pop);
        end
        if (flush) begin
            rd_ptr_d  = '0;
            wr_ptr_d  = '0;
            occ_d     = '0;
            err_ovf_d = 1'b0;
            err_unf_d = 1'b0;
        end else begin
            rd_ptr_d  = rd_ptr_q + stored_pop;
            wr_ptr_d  = wr_ptr_q + push_store;
            occ_d     = occ_q + push_store - stored_pop;
            err_ovf_d = queue_full && (push_cnt != '0);
            err_unf_d = disp_bad;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            occ_q     <= '0;
            err_ovf_q <= 1'b0;
            err_unf_q <= 1'b0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            occ_q     <= occ_d;
            err_ovf_q <= err_ovf_d;
            err_unf_q <= err_unf_d;
        end
    end

endmodule

// File: tb/tb_idu_inst_queue.sv
// Bench for idu_inst_queue: one instance without and one with bypass, both
// driven identically and compared against a queue-based reference model.
module tb_idu_inst_queue;

  typedef logic [64:0] ent_t;
  typedef ent_t ent_q_t[$];

  logic        clk = 1'b0;
  logic        rst;
  logic        flush = 1'b0;
  logic [1:0]  fetch_vld = '0;
  logic [1:0]  fetch_unalign = '0;
  logic [1:0]  dispatch_vld = '0;
  logic [63:0] fetch_inst = '0;
  logic [63:0] fetch_pc = '0;

  logic        q_full0, q_full1, eo0, eo1, eu0, eu1;
  logic [1:0]  o_vld0, o_vld1, o_ua0, o_ua1;
  logic [63:0] o_inst0, o_inst1, o_pc0, o_pc1;
  logic [3:0]  occ0, occ1;

  int          checks = 0;
  int          errors = 0;
  ent_q_t      mq0, mq1;
  logic        xo0 = 1'b0, xu0 = 1'b0, xo1 = 1'b0, xu1 = 1'b0;
  logic [31:0] pc_ctr = 32'h1000;

  always #5 clk = ~clk;

  idu_inst_queue #(.FETCH_W(2), .DISP_W(2), .DEPTH(8), .BYPASS_EN(0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush), .fetch_vld(fetch_vld),
    .fetch_inst(fetch_inst), .fetch_pc(fetch_pc), .fetch_unalign(fetch_unalign),
    .queue_full(q_full0), .out_vld(o_vld0), .out_inst(o_inst0), .out_pc(o_pc0),
    .out_unalign(o_ua0), .dispatch_vld(dispatch_vld), .occupancy(occ0),
    .err_overflow(eo0), .err_underflow(eu0)
  );

  idu_inst_queue #(.FETCH_W(2), .DISP_W(2), .DEPTH(8), .BYPASS_EN(1)) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .fetch_vld(fetch_vld),
    .fetch_inst(fetch_inst), .fetch_pc(fetch_pc), .fetch_unalign(fetch_unalign),
    .queue_full(q_full1), .out_vld(o_vld1), .out_inst(o_inst1), .out_pc(o_pc1),
    .out_unalign(o_ua1), .dispatch_vld(dispatch_vld), .occupancy(occ1),
    .err_overflow(eo1), .err_underflow(eu1)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: an ordered list of stored entries; the presented window is the
  // first two stored entries, topped up with the current beat when bypassing.
  task automatic model_step(input string nm, input bit byp, input ent_q_t qi, output ent_q_t qo,
                            input logic xo_i, input logic xu_i, output logic xo_o, output logic xu_o,
                            input logic [1:0] o_vld, input logic [63:0] o_inst, input logic [63:0] o_pc,
                            input logic [1:0] o_ua, input logic [3:0] o_occ, input logic o_full,
                            input logic o_eo, input logic o_eu);
    ent_t pres[$];
    ent_t fl[$];
    logic [1:0] exp_vld;
    logic full_now, bad;
    int n, stored;
    bit run;
    qo = qi;
    check({nm, "_err_ovf"}, 64'(o_eo), 64'(xo_i));
    check({nm, "_err_unf"}, 64'(o_eu), 64'(xu_i));
    check({nm, "_occ"}, 64'(o_occ), 64'(qo.size()));
    full_now = (8 - qo.size()) < 2;
    check({nm, "_full"}, 64'(o_full), 64'(full_now));
    for (int k = 0; k < 2; k++)
      if (fetch_vld[k]) fl.push_back({fetch_unalign[k], fetch_pc[k*32 +: 32], fetch_inst[k*32 +: 32]});
    for (int k = 0; k < qo.size() && k < 2; k++) pres.push_back(qo[k]);
    if (byp && !flush)
      for (int k = 0; k < fl.size(); k++)
        if (pres.size() < 2) pres.push_back(fl[k]);
    exp_vld = (pres.size() == 0) ? 2'b00 : (pres.size() == 1) ? 2'b01 : 2'b11;
    check({nm, "_out_vld"}, 64'(o_vld), 64'(exp_vld));
    for (int j = 0; j < pres.size(); j++) begin
      check({nm, "_inst"}, 64'(o_inst[j*32 +: 32]), 64'(pres[j][31:0]));
      check({nm, "_pc"}, 64'(o_pc[j*32 +: 32]), 64'(pres[j][63:32]));
      check({nm, "_unalign"}, 64'(o_ua[j]), 64'(pres[j][64]));
    end
    n = 0;
    run = 1'b1;
    for (int j = 0; j < 2; j++) begin
      run = run && dispatch_vld[j] && (j < pres.size());
      if (run) n++;
    end
    bad = (dispatch_vld == 2'b10) || ((dispatch_vld & ~exp_vld) != 2'b00);
    if (flush) begin
      qo.delete();
      xo_o = 1'b0;
      xu_o = 1'b0;
    end else begin
      stored = (n < qo.size()) ? n : qo.size();
      for (int k = 0; k < stored; k++) void'(qo.pop_front());
      xo_o = full_now && (fl.size() != 0);
      if (!xo_o)
        for (int k = n - stored; k < fl.size(); k++) qo.push_back(fl[k]);
      xu_o = bad;
    end
  endtask

  task automatic step(input logic [1:0] fv, input logic [1:0] dv, input logic fl);
    @(negedge clk);
    fetch_vld     = fv;
    dispatch_vld  = dv;
    flush         = fl;
    fetch_inst    = {$urandom(), $urandom()};
    fetch_unalign = 2'($urandom_range(0, 3));
    fetch_pc      = {pc_ctr + 32'd4, pc_ctr};
    pc_ctr        = pc_ctr + 32'd8;
    #1;
    model_step("d0", 1'b0, mq0, mq0, xo0, xu0, xo0, xu0, o_vld0, o_inst0, o_pc0, o_ua0, occ0, q_full0, eo0, eu0);
    model_step("d1", 1'b1, mq1, mq1, xo1, xu1, xo1, xu1, o_vld1, o_inst1, o_pc1, o_ua1, occ1, q_full1, eo1, eu1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] fv_tab [3];
    fv_tab[0] = 2'b00;
    fv_tab[1] = 2'b01;
    fv_tab[2] = 2'b11;

    // Clock/reset
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_occ0", 64'(occ0), 64'd0);
    check("rst_vld0", 64'(o_vld0), 64'd0);
    check("rst_full0", 64'(q_full0), 64'd0);
    check("rst_occ1", 64'(occ1), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Fill to capacity, then an overflowing beat
    for (int i = 0; i < 3; i++) step(2'b11, 2'b00, 1'b0);
    check("fill3_not_full", 64'(q_full0), 64'd0);
    step(2'b11, 2'b00, 1'b0);
    check("fill4_occ8", 64'(occ0), 64'd8);
    check("fill4_full", 64'(q_full0), 64'd1);
    step(2'b11, 2'b00, 1'b0);
    check("ovf_pulse", 64'(eo0), 64'd1);
    check("ovf_occ8", 64'(occ0), 64'd8);

    // Flush beats simultaneous push and pop
    step(2'b11, 2'b01, 1'b1);
    check("flush_occ0", 64'(occ0), 64'd0);
    check("flush_occ1", 64'(occ1), 64'd0);
    check("flush_vld0", 64'(o_vld0), 64'd0);
    check("flush_no_ovf", 64'(eo0), 64'd0);
    check("flush_no_unf", 64'(eu0), 64'd0);

    // Steady state at 6 with pointer wrap
    for (int i = 0; i < 3; i++) step(2'b11, 2'b00, 1'b0);
    for (int i = 0; i < 8; i++) step(2'b11, 2'b11, 1'b0);
    check("steady_occ6", 64'(occ0), 64'd6);

    // Over-dispatch with a single entry
    step(2'b00, 2'b00, 1'b1);
    step(2'b01, 2'b00, 1'b0);
    step(2'b00, 2'b11, 1'b0);
    check("unf_occ0", 64'(occ0), 64'd0);
    check("unf_pulse", 64'(eu0), 64'd1);

    // Bypass from empty
    step(2'b11, 2'b01, 1'b0);
    check("byp_occ1", 64'(occ1), 64'd1);
    check("nobyp_occ2", 64'(occ0), 64'd2);
    check("nobyp_unf", 64'(eu0), 64'd1);
    check("byp_no_unf", 64'(eu1), 64'd0);
    step(2'b00, 2'b00, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 300; i++)
      step(fv_tab[$urandom_range(0, 2)], 2'($urandom_range(0, 3)), $urandom_range(0, 19) == 0);

    // Asynchronous reset mid-cycle with 5 entries held
    step(2'b00, 2'b00, 1'b1);
    step(2'b11, 2'b00, 1'b0);
    step(2'b11, 2'b00, 1'b0);
    step(2'b01, 2'b00, 1'b0);
    check("pre_rst_occ5", 64'(occ0), 64'd5);
    @(negedge clk);
    fetch_vld = 2'b00;
    dispatch_vld = 2'b00;
    #2 rst = 1'b1;
    #1;
    check("arst_occ0", 64'(occ0), 64'd0);
    check("arst_occ1", 64'(occ1), 64'd0);
    check("arst_vld0", 64'(o_vld0), 64'd0);
    check("arst_vld1", 64'(o_vld1), 64'd0);
    check("arst_full0", 64'(q_full0), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    mq0.delete();
    mq1.delete();
    xo0 = 1'b0; xu0 = 1'b0; xo1 = 1'b0; xu1 = 1'b0;
    step(2'b01, 2'b00, 1'b0);
    step(2'b00, 2'b00, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
